// File: rtl/aes_iter_cipher.sv
// aes_iter_cipher: iterative AES encryption core computing one round per clock, free-running
module aes_iter_cipher #(
   parameter int Nk = 4,
   parameter int Nr = Nk + 6
) (
   input  logic                     clks,
   input  logic                     reset,
   input  logic [0:127]             plainText,
   input  logic [0:128*(Nr+1)-1]    keys,
   output logic [0:127]             encryptedText,
   output logic                     done
);

   typedef enum logic [1:0] {INIT, ROUNDS, FINAL} fsm_t;

   // AES S-box, byte x lives at bits [8x:8x+7]
   localparam logic [0:2047] sbox_rom = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   fsm_t         fsm, nxt_fsm;
   logic [3:0]   round_cnt, nxt_round_cnt;
   logic [0:127] state, nxt_state;
   logic [0:127] nxt_ct;
   logic         nxt_done;
   logic [0:127] round_key;
   logic [0:127] sr;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return sbox_rom[{x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [0:127] sub_bytes(input logic [0:127] s);
      for (int i = 0; i < 16; i++) sub_bytes[8*i +: 8] = sbox(s[8*i +: 8]);
   endfunction

   // row r of the output takes the byte r columns to the right (left rotation by r)
   function automatic logic [0:127] shift_rows(input logic [0:127] s);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            shift_rows[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
   endfunction

   // 2*a0 ^ 3*a1 ^ a2 ^ a3 rewritten as xtime(a0^a1) ^ a1 ^ a2 ^ a3, rotated per row
   function automatic logic [0:127] mix_columns(input logic [0:127] s);
      logic [7:0] a [4];
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) a[r] = s[8*(4*c+r) +: 8];
         for (int r = 0; r < 4; r++)
            mix_columns[8*(4*c+r) +: 8] = xtime(a[r] ^ a[(r+1)%4]) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
      end
   endfunction

   function automatic logic [0:127] add_round_key(input logic [0:127] s, input logic [0:127] k);
      return s ^ k;
   endfunction

   // the round counter doubles as the key index: 0 in INIT, 1..Nr-1 in ROUNDS, Nr in FINAL
   assign round_key = keys[128*round_cnt +: 128];
   assign sr        = shift_rows(sub_bytes(state));

   // next-state and datapath selection; SubBytes/ShiftRows are shared by middle and final rounds
   always_comb begin
      nxt_fsm       = fsm;
      nxt_round_cnt = round_cnt;
      nxt_state     = state;
      nxt_ct        = encryptedText;
      nxt_done      = 1'b0;
      case (fsm)
         INIT: begin
            nxt_state     = add_round_key(plainText, round_key);
            nxt_round_cnt = 4'd1;
            nxt_fsm       = ROUNDS;
         end
         ROUNDS: begin
            nxt_state     = add_round_key(mix_columns(sr), round_key);
            nxt_round_cnt = round_cnt + 4'd1;
            nxt_fsm       = (round_cnt == 4'(Nr-1)) ? FINAL : ROUNDS;
         end
         FINAL: begin
            nxt_ct        = add_round_key(sr, round_key);
            nxt_done      = 1'b1;
            nxt_round_cnt = 4'd0;
            nxt_fsm       = INIT;
         end
         default: nxt_fsm = INIT;
      endcase
   end

   // registers; the cipher state needs no reset because INIT always overwrites it
   always_ff @(posedge clks) begin
      state <= nxt_state;
      if (reset) begin
         fsm           <= INIT;
         round_cnt     <= 4'd0;
         encryptedText <= '0;
         done          <= 1'b0;
      end else begin
         fsm           <= nxt_fsm;
         round_cnt     <= nxt_round_cnt;
         encryptedText <= nxt_ct;
         done          <= nxt_done;
      end
   end

endmodule

// File: tb/tb_aes_iter_cipher.sv
// tb_aes_iter_cipher: FIPS-197 vectors, corner sequences and random blocks against a byte-array AES model
module tb_aes_iter_cipher;

   localparam int NR = 10;

   logic              clks = 1'b0;
   logic              reset = 1'b1;
   logic [0:127]      plainText = '0;
   logic [0:128*(NR+1)-1] keys = '0;
   logic [0:127]      encryptedText;
   logic              done;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] sb [256];

   typedef struct {
      logic [0:127] pt;
      logic [0:127] key;
      logic [0:127] ct;
   } vec_t;

   typedef struct {
      logic [7:0] b;
      logic [7:0] s;
   } sb_vec_t;

   aes_iter_cipher dut (
      .clks(clks),
      .reset(reset),
      .plainText(plainText),
      .keys(keys),
      .encryptedText(encryptedText),
      .done(done)
   );

   always #5 clks = ~clks;

   task automatic tick();
      @(posedge clks);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reset sampled on one edge, then the next edge performs INIT
   task automatic start(input logic [0:127] p, input logic [0:1407] k);
      reset = 1'b1;
      plainText = p;
      keys = k;
      tick();
      reset = 1'b0;
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [0:1407] expand(input logic [0:127] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 44; i++) expand[32*i +: 32] = w[i];
   endfunction

   function automatic logic [0:127] ref_enc(input logic [0:127] p, input logic [0:1407] ks);
      logic [7:0] s [16];
      logic [7:0] t [16];
      for (int i = 0; i < 16; i++) s[i] = p[8*i +: 8] ^ ks[8*i +: 8];
      for (int r = 1; r <= NR; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
         if (r < NR) begin
            for (int c = 0; c < 4; c++)
               for (int w = 0; w < 4; w++)
                  t[4*c+w] = gmul(8'h02, s[4*c+w]) ^ gmul(8'h03, s[4*c+(w+1)%4]) ^ s[4*c+(w+2)%4] ^ s[4*c+(w+3)%4];
            for (int i = 0; i < 16; i++) s[i] = t[i];
         end
         for (int i = 0; i < 16; i++) s[i] ^= ks[128*r + 8*i +: 8];
      end
      for (int i = 0; i < 16; i++) ref_enc[8*i +: 8] = s[i];
   endfunction

   initial begin
      vec_t          vecs [2];
      sb_vec_t       sbv [4];
      logic [0:1407] ks_c1, ks_b, ks_r;
      logic [0:127]  ct_c1, pt_r;
      logic [7:0]    inv;

      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end

      vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      vecs[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32};
      sbv[0] = '{8'h00, 8'h63};
      sbv[1] = '{8'h53, 8'hed};
      sbv[2] = '{8'hff, 8'h16};
      sbv[3] = '{8'h01, 8'h7c};
      ks_c1 = expand(vecs[0].key);
      ks_b  = expand(vecs[1].key);
      ct_c1 = vecs[0].ct;

      // reset state
      reset = 1'b1;
      tick();
      tick();
      chk("reset ct", encryptedText, 128'h0);
      chk("reset done", 128'(done), 128'h0);
      chk("reset round", 128'(dut.round_cnt), 128'h0);

      // C.1 with intermediate states and exact done timing
      start(vecs[0].pt, ks_c1);
      tick();
      chk("c1 init state", dut.state, 128'h00102030405060708090a0b0c0d0e0f0);
      chk("c1 done e1", 128'(done), 128'h0);
      tick();
      chk("c1 round1 state", dut.state, 128'h89d810e8855ace682d1843d8cb128fe4);
      for (int e = 3; e <= 10; e++) begin
         tick();
         chk($sformatf("c1 done e%0d", e), 128'(done), 128'h0);
      end
      tick();
      chk("c1 ct e11", encryptedText, ct_c1);
      chk("c1 done e11", 128'(done), 128'h1);
      tick();
      chk("c1 done e12", 128'(done), 128'h0);
      chk("c1 ct hold e12", encryptedText, ct_c1);

      // known-answer table
      for (int v = 0; v < 2; v++) begin
         start(vecs[v].pt, expand(vecs[v].key));
         for (int e = 1; e <= 11; e++) tick();
         chk($sformatf("kat%0d ct", v), encryptedText, vecs[v].ct);
         chk($sformatf("kat%0d done", v), 128'(done), 128'h1);
      end

      // SubBytes: uniform state with zero keys makes MixColumns the identity
      for (int v = 0; v < 4; v++) begin
         start({16{sbv[v].b}}, '0);
         tick();
         tick();
         chk($sformatf("sbox %h", sbv[v].b), dut.state, {16{sbv[v].s}});
      end

      // free run with constant inputs
      start(vecs[0].pt, ks_c1);
      for (int e = 1; e <= 44; e++) begin
         tick();
         chk($sformatf("free done e%0d", e), 128'(done), 128'(e % 11 == 0));
         chk($sformatf("free ct e%0d", e), encryptedText, (e < 11) ? 128'h0 : ct_c1);
         chk($sformatf("free round e%0d", e), 128'(dut.round_cnt <= 4'd10), 128'h1);
      end

      // reset at round 5 of the next block
      for (int e = 1; e <= 5; e++) tick();
      chk("mid round", 128'(dut.round_cnt), 128'h5);
      reset = 1'b1;
      tick();
      chk("rst ct", encryptedText, 128'h0);
      chk("rst done", 128'(done), 128'h0);
      chk("rst round", 128'(dut.round_cnt), 128'h0);
      reset = 1'b0;
      for (int e = 1; e <= 11; e++) begin
         tick();
         chk($sformatf("post-rst done e%0d", e), 128'(done), 128'(e == 11));
         chk($sformatf("post-rst ct e%0d", e), encryptedText, (e == 11) ? ct_c1 : 128'h0);
      end

      // plaintext change during ROUNDS only affects the next block
      start(vecs[0].pt, ks_c1);
      for (int e = 1; e <= 5; e++) tick();
      plainText = vecs[1].pt;
      for (int e = 6; e <= 11; e++) tick();
      chk("midchg ct1", encryptedText, ct_c1);
      chk("midchg done1", 128'(done), 128'h1);
      keys = ks_b;
      for (int e = 1; e <= 11; e++) tick();
      chk("midchg ct2", encryptedText, vecs[1].ct);
      chk("midchg done2", 128'(done), 128'h1);

      // random plaintexts and arbitrary key schedules
      for (int n = 0; n < 20; n++) begin
         pt_r = {$urandom, $urandom, $urandom, $urandom};
         for (int i = 0; i < 44; i++) ks_r[32*i +: 32] = $urandom;
         start(pt_r, ks_r);
         for (int e = 1; e <= 11; e++) tick();
         chk($sformatf("rand%0d ct", n), encryptedText, ref_enc(pt_r, ks_r));
         chk($sformatf("rand%0d done", n), 128'(done), 128'h1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
